// File: rtl/seg_display_pkg.sv
// Shared definitions for the seven-segment display array: bus size codes,
// CTRL bit positions, the hex font and register-map helpers.
package seg_display_pkg;

  typedef enum logic [1:0] {
    SZ_NONE = 2'b00,
    SZ_BYTE = 2'b01,
    SZ_HALF = 2'b10,
    SZ_WORD = 2'b11
  } size_e;

  localparam int CTRL_HEX_MODE = 0;
  localparam int CTRL_BLINK_EN = 1;
  localparam int CTRL_BLANK    = 2;
  localparam int CTRL_W        = 3;

  // Segment order g..a in bits 6:0; entry 15 ('F') first, entry 0 ('0') last.
  localparam logic [15:0][6:0] HEX_FONT = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  // Byte offset of CTRL: digit bytes rounded up to a whole number of words.
  function automatic int ctrl_offset(int num_digits);
    return 4 * ((num_digits + 3) / 4);
  endfunction

  function automatic logic [2:0] size_bytes(size_e sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  function automatic logic size_aligned(size_e sz, logic [1:0] off);
    case (sz)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return (off[0] == 1'b0);
      SZ_WORD: return (off == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_if.sv
// CPU-side address/control group of the display bus; the tristate data lines
// stay a plain inout port on the slave.
interface seg_display_if;
  import seg_display_pkg::*;

  logic [31:0] addr;
  logic        rw;
  size_e       size;

  modport master (output addr, output rw, output size);
  modport slave  (input  addr, input  rw, input  size);

endinterface

// File: rtl/seg_hex_decoder.sv
// Combinational nibble to seven-segment (g..a) font lookup.
module seg_hex_decoder
  import seg_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segs
);

  assign segs = HEX_FONT[nibble];

endmodule

// File: rtl/seg_display_array.sv
// Memory-mapped seven-segment display array: NUM_DIGITS digit bytes plus a CTRL
// word on the CPU bus, driving static per-digit pins and a multiplexed scan port.
module seg_display_array
  import seg_display_pkg::*;
#(
  parameter logic [31:0] BASE       = 32'h8000_0004,
  parameter int          NUM_DIGITS = 4,
  parameter int          SCAN_DIV   = 1000,
  parameter int          BLINK_DIV  = 25_000_000,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  seg_display_if.slave            bus,
  inout  wire  [31:0]             data,
  output logic [8*NUM_DIGITS-1:0] seg_static,
  output logic [7:0]              seg_scan,
  output logic [NUM_DIGITS-1:0]   dig_sel
);

  localparam int          CTRL_OFF = ctrl_offset(NUM_DIGITS);
  localparam logic [31:0] WIN_SIZE = 32'(CTRL_OFF + 4);
  localparam int          SCAN_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int          BLINK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int          IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [7:0]  UNLIT    = ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_SEL_RST =
    ACTIVE_LOW ? ~NUM_DIGITS'(1) : NUM_DIGITS'(1);

  // Register state
  logic [NUM_DIGITS-1:0][7:0] digit_q, digit_d;
  logic [CTRL_W-1:0]          ctrl_q, ctrl_d;
  logic [31:0]                rd_buf_q, rd_buf_d;
  logic [BLINK_W-1:0]         blink_cnt_q, blink_cnt_d;
  logic                       blink_phase_q, blink_phase_d;
  logic [SCAN_W-1:0]          scan_cnt_q, scan_cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_DIGITS-1:0][7:0] seg_static_q, seg_static_d;
  logic [7:0]                 seg_scan_q, seg_scan_d;
  logic [NUM_DIGITS-1:0]      dig_sel_q, dig_sel_d;

  // Bus decode
  logic [31:0] offset;
  logic        in_window;
  logic        aligned;
  logic [2:0]  n_bytes;
  logic        wr_en;
  logic        rd_en;

  always_comb begin
    offset    = bus.addr - BASE;
    in_window = (bus.addr >= BASE) && (offset < WIN_SIZE);
    aligned   = size_aligned(bus.size, offset[1:0]);
    n_bytes   = size_bytes(bus.size);
    wr_en     = in_window && (bus.size != SZ_NONE) && bus.rw && aligned;
    rd_en     = in_window && (bus.size != SZ_NONE) && !bus.rw;
  end

  // Byte lane j of the bus maps to register byte offset+j; pad bytes and the
  // upper three CTRL bytes have no storage, so they simply never match.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    digit_d = digit_q;
    ctrl_d  = ctrl_q;
    if (wr_en) begin
      for (int j = 0; j < 4; j++) begin
        if (3'(j) < n_bytes) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (offset + 32'(j) == 32'(i)) digit_d[i] = data[8*j +: 8];
          end
          if (offset + 32'(j) == 32'(CTRL_OFF)) ctrl_d = data[8*j +: CTRL_W];
        end
      end
    end
  end

  // Misaligned reads leave every lane zero; pads read zero by default.
  always_comb begin
    rd_buf_d = rd_buf_q;
    if (rd_en) begin
      rd_buf_d = '0;
      for (int j = 0; j < 4; j++) begin
        if (aligned && (3'(j) < n_bytes)) begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (offset + 32'(j) == 32'(i)) rd_buf_d[8*j +: 8] = digit_q[i];
          end
          if (offset + 32'(j) == 32'(CTRL_OFF)) begin
            rd_buf_d[8*j +: 8] = {{(8-CTRL_W){1'b0}}, ctrl_q};
          end
        end
      end
    end
  end

  assign data = (rd_en && rst_n) ? rd_buf_q : {32{1'bz}};

  // Free-running blink and scan timebases
  logic blink_wrap;
  logic scan_wrap;

  always_comb begin
    blink_wrap    = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    blink_cnt_d   = blink_wrap ? '0 : blink_cnt_q + 1'b1;
    blink_phase_d = blink_phase_q ^ blink_wrap;

    scan_wrap  = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
    idx_d      = idx_q;
    if (scan_wrap) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // Display path
  logic [NUM_DIGITS-1:0][6:0] font;
  logic                       mask_off;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decoder u_dec (
      .nibble (digit_q[g][3:0]),
      .segs   (font[g])
    );
  end

  // XOR with UNLIT turns the lit pattern into pin polarity in one step.
  always_comb begin
    mask_off   = ctrl_q[CTRL_BLANK] | (ctrl_q[CTRL_BLINK_EN] & blink_phase_q);
    seg_scan_d = UNLIT;
    dig_sel_d  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seg_static_d[i] = UNLIT ^ (mask_off ? 8'h00 :
                                 (ctrl_q[CTRL_HEX_MODE] ? {digit_q[i][7], font[i]}
                                                        : digit_q[i]));
      dig_sel_d[i] = ACTIVE_LOW ^ (idx_q == IDX_W'(i));
    end
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) seg_scan_d = seg_static_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the digit bytes are reset too; they are few, and software expects a blank display.
      digit_q       <= '0;
      ctrl_q        <= '0;
      rd_buf_q      <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      scan_cnt_q    <= '0;
      idx_q         <= '0;
      seg_static_q  <= {NUM_DIGITS{UNLIT}};
      seg_scan_q    <= UNLIT;
      dig_sel_q     <= DIG_SEL_RST;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      digit_q       <= digit_d;
      ctrl_q        <= ctrl_d;
      rd_buf_q      <= rd_buf_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      scan_cnt_q    <= scan_cnt_d;
      idx_q         <= idx_d;
      seg_static_q  <= seg_static_d;
      seg_scan_q    <= seg_scan_d;
      dig_sel_q     <= dig_sel_d;
    end
  end

  assign seg_static = seg_static_q;
  assign seg_scan   = seg_scan_q;
  assign dig_sel    = dig_sel_q;

endmodule

// File: tb/tb_seg_display_array.sv
// Scoreboard bench for seg_display_array: a 4-digit and a 6-digit instance share
// one bus; stimulus queues expected values, a negedge monitor compares them.
module tb_seg_display_array;
  import seg_display_pkg::*;

  localparam logic [31:0] BASE_A = 32'h8000_0004;
  localparam logic [31:0] CTRL_A = BASE_A + 32'd4;
  localparam logic [31:0] BASE_B = 32'h8000_0100;
  localparam logic [31:0] CTRL_B = BASE_B + 32'd8;
  localparam logic [31:0] UNDRIVEN = 32'hFFFF_FFFF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_display_if bus ();
  tri1 [31:0] data;
  logic        tb_oe;
  logic [31:0] tb_wdata;
  assign data = tb_oe ? tb_wdata : {32{1'bz}};

  logic [31:0] seg_static_a;
  logic [7:0]  seg_scan_a;
  logic [3:0]  dig_sel_a;
  logic [47:0] seg_static_b;
  logic [7:0]  seg_scan_b;
  logic [5:0]  dig_sel_b;

  seg_display_array #(
    .BASE(BASE_A), .NUM_DIGITS(4), .SCAN_DIV(3), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus), .data(data),
    .seg_static(seg_static_a), .seg_scan(seg_scan_a), .dig_sel(dig_sel_a)
  );

  seg_display_array #(
    .BASE(BASE_B), .NUM_DIGITS(6), .SCAN_DIV(3), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus), .data(data),
    .seg_static(seg_static_b), .seg_scan(seg_scan_b), .dig_sel(dig_sel_b)
  );

  typedef enum int {
    SIG_DATA, SIG_STATIC_A, SIG_SCAN_A, SIG_DIGSEL_A,
    SIG_STATIC_B, SIG_SCAN_B, SIG_DIGSEL_B
  } sig_e;

  typedef struct {
    sig_e        sig;
    logic [63:0] exp;
    string       name;
    int          cyc;
  } exp_t;

  exp_t sb_q[$];
  int   cyc       = 0;
  int   run_edges = 0;
  int   checks    = 0;
  int   errors    = 0;

  // run_edges counts edges since reset release; it drives the blink/scan model.
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    run_edges <= rst_n ? run_edges + 1 : 0;
  end

  function automatic logic [63:0] sample(sig_e s);
    case (s)
      SIG_DATA:     return {32'h0, data};
      SIG_STATIC_A: return {32'h0, seg_static_a};
      SIG_SCAN_A:   return {56'h0, seg_scan_a};
      SIG_DIGSEL_A: return {60'h0, dig_sel_a};
      SIG_STATIC_B: return {16'h0, seg_static_b};
      SIG_SCAN_B:   return {56'h0, seg_scan_b};
      default:      return {58'h0, dig_sel_b};
    endcase
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    while (sb_q.size() != 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check(e.name, sample(e.sig), e.exp);
    end
  end

  task automatic push_exp(sig_e sig, logic [63:0] exp, string name);
    exp_t e;
    e.sig  = sig;
    e.exp  = exp;
    e.name = name;
    e.cyc  = cyc;
    sb_q.push_back(e);
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    bus.addr = '0;
    bus.rw   = 1'b0;
    bus.size = SZ_NONE;
    tb_oe    = 1'b0;
    tb_wdata = '0;
  endtask

  task automatic bus_write(logic [31:0] a, logic [31:0] d, size_e sz);
    bus.addr = a;
    bus.rw   = 1'b1;
    bus.size = sz;
    tb_wdata = d;
    tb_oe    = 1'b1;
    tick();
    bus_idle();
  endtask

  // Address held for two cycles; data is sampled in the second one.
  task automatic bus_read(logic [31:0] a, size_e sz, logic [31:0] exp, string name);
    bus.addr = a;
    bus.rw   = 1'b0;
    bus.size = sz;
    tick();
    push_exp(SIG_DATA, {32'h0, exp}, name);
    tick();
    bus_idle();
  endtask

  // Expected scan outputs for dut_a given the static pin value it should show.
  task automatic push_scan_a(logic [31:0] static_exp, string tag);
    int          idx;
    logic [3:0]  ds;
    idx = (run_edges == 0) ? 0 : ((run_edges - 1) / 3) % 4;
    ds  = ~(4'b0001 << idx);
    push_exp(SIG_DIGSEL_A, {60'h0, ds}, {tag, "_dig_sel"});
    push_exp(SIG_SCAN_A, {56'h0, static_exp[8*idx +: 8]}, {tag, "_seg_scan"});
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] exp_a;
    rst_n = 1'b0;
    bus_idle();
    tick(2);
    push_exp(SIG_STATIC_A, {32'h0, 32'hFFFF_FFFF}, "reset_static_a");
    push_exp(SIG_SCAN_A,   64'hFF,                  "reset_scan_a");
    push_exp(SIG_DIGSEL_A, 64'hE,                   "reset_dig_sel_a");
    push_exp(SIG_STATIC_B, 64'hFFFF_FFFF_FFFF,      "reset_static_b");
    push_exp(SIG_SCAN_B,   64'hFF,                  "reset_scan_b");
    push_exp(SIG_DIGSEL_B, 64'h3E,                  "reset_dig_sel_b");
    push_exp(SIG_DATA,     {32'h0, UNDRIVEN},       "reset_data_z");
    tick();
    rst_n = 1'b1;
    tick();

    // Word write, one-cycle pin latency, read-back
    bus_write(BASE_A, 32'h4F5B_063F, SZ_WORD);
    push_exp(SIG_STATIC_A, {32'h0, 32'hFFFF_FFFF}, "word_write_latency");
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'hB0A4_F9C0}, "word_write_pins");
    bus_read(BASE_A, SZ_WORD, 32'h4F5B_063F, "word_read");

    // Six-digit instance: half write, pad byte, CTRL at BASE+8
    bus_write(BASE_B + 32'd4, 32'h0000_ABCD, SZ_HALF);
    tick();
    push_exp(SIG_STATIC_B, 64'h5432_FFFF_FFFF, "half_write_b");
    bus_write(BASE_B + 32'd6, 32'h0000_0012, SZ_BYTE);
    tick();
    push_exp(SIG_STATIC_B, 64'h5432_FFFF_FFFF, "pad_write_ignored");
    bus_read(BASE_B + 32'd6, SZ_BYTE, 32'h0, "pad_read_zero");
    bus_read(BASE_B + 32'd4, SZ_WORD, 32'h0000_ABCD, "word_read_with_pads");
    bus_write(CTRL_B, 32'hFFFF_FFF9, SZ_WORD);
    tick();
    push_exp(SIG_STATIC_B, 64'h0321_C0C0_C0C0, "hex_mode_b");
    bus_read(CTRL_B, SZ_WORD, 32'h0000_0001, "ctrl_read_b");

    // Misaligned and out-of-window accesses on the four-digit instance
    bus_write(BASE_A + 32'd1, 32'h0000_FFFF, SZ_HALF);
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'hB0A4_F9C0}, "misaligned_half_write");
    bus_read(BASE_A + 32'd1, SZ_HALF, 32'h0, "misaligned_half_read");
    bus_write(BASE_A + 32'd2, 32'h1122_3344, SZ_WORD);
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'hB0A4_F9C0}, "misaligned_word_write");
    bus_read(BASE_A + 32'd2, SZ_HALF, 32'h0000_4F5B, "aligned_half_read");
    bus_read(BASE_A + 32'd16, SZ_WORD, UNDRIVEN, "outside_window_z");
    bus_read(BASE_A - 32'd4, SZ_WORD, UNDRIVEN, "below_window_z");

    // Hex mode with decimal point
    bus_write(CTRL_A, 32'h0000_0001, SZ_WORD);
    bus_write(BASE_A, 32'h0000_008A, SZ_BYTE);
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'h8E83_8208}, "hex_mode_dp");

    // Blink: pins follow the blink phase, scan follows its own timebase
    bus_write(CTRL_A, 32'h0000_0003, SZ_WORD);
    tick();
    for (int k = 0; k < 12; k++) begin
      exp_a = ((((run_edges - 1) / 4) % 2) == 1) ? 32'hFFFF_FFFF : 32'h8E83_8208;
      push_exp(SIG_STATIC_A, {32'h0, exp_a}, "blink");
      push_scan_a(exp_a, "blink");
      tick();
    end

    // Blank takes effect one cycle after the CTRL write
    bus_write(CTRL_A, 32'h0000_0001, SZ_WORD);
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'h8E83_8208}, "blink_off_lit");
    bus_write(CTRL_A, 32'h0000_0005, SZ_WORD);
    push_exp(SIG_STATIC_A, {32'h0, 32'h8E83_8208}, "blank_latency");
    tick();
    push_exp(SIG_STATIC_A, {32'h0, 32'hFFFF_FFFF}, "blank_unlit");
    push_exp(SIG_SCAN_A,   64'hFF,                  "blank_scan_unlit");

    // Reset mid-scan together with a write
    bus_write(CTRL_A, 32'h0000_0001, SZ_WORD);
    tick(4);
    rst_n    = 1'b0;
    bus.addr = BASE_A;
    bus.rw   = 1'b1;
    bus.size = SZ_WORD;
    tb_wdata = 32'h3F3F_3F3F;
    tb_oe    = 1'b1;
    tick();
    bus_idle();
    push_exp(SIG_STATIC_A, {32'h0, 32'hFFFF_FFFF}, "reset_write_static");
    push_exp(SIG_SCAN_A,   64'hFF,                  "reset_write_scan");
    push_exp(SIG_DIGSEL_A, 64'hE,                   "reset_write_dig_sel");
    tick();
    rst_n = 1'b1;
    bus_read(BASE_A, SZ_WORD, 32'h0, "reset_write_discarded");
    bus_read(CTRL_A, SZ_WORD, 32'h0, "reset_ctrl_cleared");

    // Scan rotation after reset
    bus_write(BASE_A, 32'h4F5B_063F, SZ_WORD);
    tick();
    for (int k = 0; k < 14; k++) begin
      push_exp(SIG_STATIC_A, {32'h0, 32'hB0A4_F9C0}, "scan_static");
      push_scan_a(32'hB0A4_F9C0, "scan");
      tick();
    end

    tick(2);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: pending %0d required 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
